// File: rtl/muldiv_issue.sv
// HI/LO issue controller: hands MULT/DIV ops to a multicycle unit, owns HI/LO, serves MFHI/MFLO.
// Optional macro HILO_BYPASS_EN forwards unit results to the read port on the completion cycle.
module muldiv_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        md_start,
  output logic [4:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  input  logic        md_done,
  input  logic        rd_en,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        busy_stall,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q,
  output logic        timeout_err
);

  localparam logic [4:0] OpMthi    = 5'b01001;
  localparam logic [4:0] OpMtlo    = 5'b01011;
  localparam logic [5:0] DrainLast = 6'd39;
  localparam logic [5:0] WaitLast  = 6'd63;

  typedef enum logic [1:0] {StDrain, StIdle, StIssue, StWait} state_e;

  state_e     state_q;
  logic [5:0] cnt_q;
  logic       accept;
  logic       is_md_op;
  logic       bypass;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid & req_ready;
  // MULT/MULTU/DIV/DIVU are exactly the opcodes 011xx.
  assign is_md_op  = (req_op[4:2] == 3'b011);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StDrain;
      cnt_q       <= 6'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      md_start    <= 1'b0;
      md_op       <= 5'd0;
      md_a        <= 32'd0;
      md_b        <= 32'd0;
      timeout_err <= 1'b0;
    end else begin
      md_start    <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state_q)
        StDrain: begin
          if (cnt_q == DrainLast) begin
            state_q <= StIdle;
            cnt_q   <= 6'd0;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        StIdle: begin
          if (accept) begin
            if (is_md_op) begin
              md_op    <= req_op;
              md_a     <= req_a;
              md_b     <= req_b;
              md_start <= 1'b1;
              state_q  <= StIssue;
            end else if (req_op == OpMthi) begin
              hi_q <= req_a;
            end else if (req_op == OpMtlo) begin
              lo_q <= req_a;
            end
          end
        end
        StIssue: begin
          state_q <= StWait;
          cnt_q   <= 6'd0;
        end
        StWait: begin
          if (md_done) begin
            hi_q    <= md_hi;
            lo_q    <= md_lo;
            md_op   <= 5'd0;
            state_q <= StIdle;
          end else if (cnt_q == WaitLast) begin
            timeout_err <= 1'b1;
            md_op       <= 5'd0;
            state_q     <= StIdle;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        default: state_q <= StDrain;
      endcase
    end
  end

`ifdef HILO_BYPASS_EN
  assign bypass = (state_q == StWait) & md_done;
`else
  assign bypass = 1'b0;
`endif

  assign rd_data    = bypass ? (rd_sel ? md_hi : md_lo) : (rd_sel ? hi_q : lo_q);
  assign busy_stall = rd_en & (state_q != StIdle) & ~bypass;

endmodule

// File: tb/tb_muldiv_issue.sv
// Directed self-checking bench for muldiv_issue; the bench plays the multicycle unit.
module tb_muldiv_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_op = 5'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic        md_start;
  logic [4:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [31:0] md_hi = 32'd0;
  logic [31:0] md_lo = 32'd0;
  logic        md_done = 1'b0;
  logic        rd_en = 1'b0;
  logic        rd_sel = 1'b0;
  logic [31:0] rd_data;
  logic        busy_stall;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        timeout_err;

  muldiv_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .md_start    (md_start),
    .md_op       (md_op),
    .md_a        (md_a),
    .md_b        (md_b),
    .md_hi       (md_hi),
    .md_lo       (md_lo),
    .md_done     (md_done),
    .rd_en       (rd_en),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data),
    .busy_stall  (busy_stall),
    .hi_q        (hi_q),
    .lo_q        (lo_q),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-operation observations gathered by run_op.
  int          starts;
  int          busy_cycles;
  bit          op_bad;
  bit          to_seen;
  bit          stall_bad;
  bit          done_stall;
  logic [31:0] done_rd;
  bit          post_stall;
  logic [31:0] post_rd;
  bit          accept_rdy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drain_count(output int n);
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      n++;
      @(posedge clk); #1;
      md_done = (n == 5);
      md_hi   = 32'hDEAD_BEEF;
      md_lo   = 32'hCAFE_F00D;
      @(negedge clk);
    end
    md_done = 1'b0;
  endtask

  // Issue one unit op and act as the unit: md_done arrives in WAIT cycle number lat.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input bit respond,
                        input logic [31:0] rhi, input logic [31:0] rlo);
    int wait_n;
    starts = 0; busy_cycles = 0; op_bad = 0; to_seen = 0; stall_bad = 0;
    done_stall = 0; done_rd = 32'd0; wait_n = -1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    accept_rdy = req_ready;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 5'd0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (req_ready) begin
        to_seen = timeout_err;
        break;
      end
      busy_cycles++;
      if (md_start) begin
        starts++;
        wait_n = 0;
      end
      if (md_op !== op || md_a !== a || md_b !== b) op_bad = 1;
      if (md_done) begin
        done_stall = busy_stall;
        done_rd    = rd_data;
      end else if (rd_en && !busy_stall) begin
        stall_bad = 1;
      end
      @(posedge clk); #1;
      md_done = 1'b0;
      if (wait_n >= 0) begin
        wait_n++;
        if (respond && wait_n == lat) begin
          md_done = 1'b1; md_hi = rhi; md_lo = rlo;
        end
      end
    end
    post_stall = busy_stall;
    post_rd    = rd_data;
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_hi", hi_q, 0);
    check("rst_lo", lo_q, 0);
    check("rst_start", md_start, 0);
    check("rst_op", md_op, 0);
    check("rst_ready", req_ready, 0);
    check("rst_to", timeout_err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drain_count(n);
    check("drain_len", n, 40);
    check("drain_stray_hi", hi_q, 0);
    check("drain_stray_lo", lo_q, 0);

    // MULT -3 * 5
    run_op(5'b01100, 32'hFFFF_FFFD, 32'd5, 34, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    check("mult_accept", accept_rdy, 1);
    check("mult_starts", starts, 1);
    check("mult_op_stable", op_bad, 0);
    check("mult_busy", busy_cycles, 35);
    check("mult_hi", hi_q, 32'hFFFF_FFFF);
    check("mult_lo", lo_q, 32'hFFFF_FFF1);
    check("idle_md_op", md_op, 0);

    // DIVU 100 / 7
    run_op(5'b01111, 32'd100, 32'd7, 34, 1'b1, 32'd2, 32'd14);
    check("divu_busy", busy_cycles, 35);
    check("divu_lo", lo_q, 14);
    check("divu_hi", hi_q, 2);

    // DIV -20 / 6 with MFLO held throughout
    rd_en = 1'b1; rd_sel = 1'b0;
    run_op(5'b01110, 32'hFFFF_FFEC, 32'd6, 10, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    check("div_stall_wait", stall_bad, 0);
`ifdef HILO_BYPASS_EN
    check("div_done_stall", done_stall, 0);
    check("div_done_rd", done_rd, 32'hFFFF_FFFD);
`else
    check("div_done_stall", done_stall, 1);
`endif
    check("div_post_stall", post_stall, 0);
    check("div_post_rd", post_rd, 32'hFFFF_FFFD);
    check("div_hi", hi_q, 32'hFFFF_FFFE);

    // MTHI with a same-cycle MFHI, then MFHI next cycle
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 5'b01001; req_a = 32'h1234_5678; rd_en = 1'b1; rd_sel = 1'b1;
    @(negedge clk);
    check("mthi_same_rd", rd_data, 32'hFFFF_FFFE);
    check("mthi_start0", md_start, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("mthi_rd", rd_data, 32'h1234_5678);
    check("mthi_stall", busy_stall, 0);
    check("mthi_start1", md_start, 0);
    check("mthi_ready", req_ready, 1);

    // MTLO, then unknown opcode and a stray md_done while idle
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 5'b01011; req_a = 32'h0BAD_F00D; rd_sel = 1'b0;
    @(posedge clk); #1;
    req_op = 5'b00001; req_a = 32'h5555_AAAA;
    md_done = 1'b1; md_hi = 32'h7777_7777; md_lo = 32'h8888_8888;
    @(posedge clk); #1;
    req_valid = 1'b0; md_done = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    check("mtlo_lo", lo_q, 32'h0BAD_F00D);
    check("unk_hi", hi_q, 32'h1234_5678);
    check("unk_ready", req_ready, 1);
    check("unk_start", md_start, 0);

    // Unit never answers
    run_op(5'b01100, 32'd3, 32'd4, 0, 1'b0, 32'd0, 32'd0);
    check("to_busy", busy_cycles, 65);
    check("to_pulse_ready", to_seen, 1);
    check("to_hi", hi_q, 32'h1234_5678);
    check("to_lo", lo_q, 32'h0BAD_F00D);
    @(negedge clk);
    check("to_one_cycle", timeout_err, 0);

    // Reset 10 cycles into a MULTU
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 5'b01101; req_a = 32'd9; req_b = 32'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("mrst_hi", hi_q, 0);
    check("mrst_lo", lo_q, 0);
    check("mrst_op", md_op, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drain_count(n);
    check("mrst_drain_len", n, 40);
    check("mrst_ready", req_ready, 1);
    check("mrst_stray_hi", hi_q, 0);
    check("mrst_stray_lo", lo_q, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
